// File: rtl/ms_wdt.sv
// rtl/ms_wdt.sv - keyed watchdog timer with prescaler, early warning and reset-request pulse.
// Optional MS_WDT_LOCK_EN: en is locked once running and FIRE reloads straight back into RUN.
module ms_wdt #(
  parameter int          CNT_W   = 16,
  parameter int          PULSE_W = 16,
  parameter logic [7:0]  KEY0    = 8'hA5,
  parameter logic [7:0]  KEY1    = 8'h5A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] load,
  input  logic [CNT_W-1:0] warn,
  input  logic [1:0]       prescale,
  input  logic             kick_valid,
  input  logic [7:0]       kick_key,
  output logic             rst_req_n,
  output logic             irq_warn,
  output logic             wdt_fired,
  output logic [CNT_W-1:0] count
);

  localparam int              PC_W    = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PULSE_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIRE} state_t;

  state_t           state;
  logic [11:0]      presc;
  logic             unlock;
  logic [PC_W-1:0]  pulse_cnt;
  logic             tick;
  logic             valid_kick;
  logic [CNT_W-1:0] load_eff;
  logic [CNT_W-1:0] count_dec;

  assign load_eff   = (load == '0) ? CNT_W'(1) : load;
  assign count_dec  = count - CNT_W'(1);
  assign valid_kick = kick_valid && unlock && (kick_key == KEY1);

  always_comb begin
    tick = 1'b0;
    case (prescale)
      2'b00:   tick = 1'b1;
      2'b01:   tick = &presc[3:0];
      2'b10:   tick = &presc[7:0];
      default: tick = &presc[11:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      presc     <= '0;
      unlock    <= 1'b0;
      pulse_cnt <= '0;
      rst_req_n <= 1'b1;
      irq_warn  <= 1'b0;
      wdt_fired <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          count     <= load_eff;
          presc     <= '0;
          unlock    <= 1'b0;
          irq_warn  <= 1'b0;
          rst_req_n <= 1'b1;
          if (en) state <= RUN;
        end
        RUN: begin
`ifndef MS_WDT_LOCK_EN
          if (!en) begin
            state    <= IDLE;
            irq_warn <= 1'b0;
            unlock   <= 1'b0;
            presc    <= '0;
          end else
`endif
          if (valid_kick) begin
            // a kick on the terminal tick still wins: reload, never FIRE
            count    <= load_eff;
            presc    <= '0;
            unlock   <= 1'b0;
            irq_warn <= 1'b0;
          end else begin
            if (kick_valid) unlock <= (kick_key == KEY0);
            presc <= presc + 12'd1;
            if (tick) begin
              if (count <= CNT_W'(1)) begin
                count     <= '0;
                state     <= FIRE;
                wdt_fired <= 1'b1;
                rst_req_n <= 1'b0;
                pulse_cnt <= '0;
                irq_warn  <= 1'b1;
              end else begin
                count <= count_dec;
                if (count_dec <= warn) irq_warn <= 1'b1;
              end
            end
          end
        end
        FIRE: begin
          unlock <= 1'b0;
          if (pulse_cnt == PC_LAST) begin
            rst_req_n <= 1'b1;
`ifdef MS_WDT_LOCK_EN
            state    <= RUN;
            count    <= load_eff;
            presc    <= '0;
            irq_warn <= 1'b0;
`else
            state    <= IDLE;
`endif
          end else begin
            pulse_cnt <= pulse_cnt + PC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ms_wdt.sv
// tb/tb_ms_wdt.sv - scoreboard bench for ms_wdt against a tick-counting reference model.
module tb_ms_wdt;

  localparam int         CNT_W   = 16;
  localparam int         PULSE_W = 16;
  localparam logic [7:0] KEY0    = 8'hA5;
  localparam logic [7:0] KEY1    = 8'h5A;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_FIRE = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [CNT_W-1:0] load = '0;
  logic [CNT_W-1:0] warn = '0;
  logic [1:0]       prescale = 2'b00;
  logic             kick_valid = 1'b0;
  logic [7:0]       kick_key = 8'h00;
  logic             rst_req_n;
  logic             irq_warn;
  logic             wdt_fired;
  logic [CNT_W-1:0] count;

  ms_wdt #(.CNT_W(CNT_W), .PULSE_W(PULSE_W), .KEY0(KEY0), .KEY1(KEY1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .warn(warn), .prescale(prescale),
    .kick_valid(kick_valid), .kick_key(kick_key), .rst_req_n(rst_req_n),
    .irq_warn(irq_warn), .wdt_fired(wdt_fired), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               phase;
    logic [CNT_W-1:0] count;
    logic             rstn;
    logic             irq;
    logic             fired;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   phase    = 0;

  // Reference model: count is the reload value minus ticks seen since that reload;
  // a tick is every div-th RUN cycle counted from the reload.
  int m_state, m_base, m_ticks, m_n, m_pulse, m_last_key;
  bit m_irq, m_fired, m_rstn;

  function automatic int m_cnt();
    return m_base - m_ticks;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_base = 0; m_ticks = 0; m_n = 0; m_pulse = 0;
    m_last_key = -1; m_irq = 0; m_fired = 0; m_rstn = 1;
  endtask

  task automatic model_reload(input int le);
    m_base = le; m_ticks = 0; m_n = 0; m_irq = 0; m_last_key = -1;
  endtask

  task automatic model_step(input bit e, input int ld, input int wr, input int ps,
                            input bit kv, input int kk);
    int le;
    int div;
    bit valid;
    le  = (ld == 0) ? 1 : ld;
    div = 1 << (4 * ps);
    case (m_state)
      S_IDLE: begin
        model_reload(le);
        if (e) m_state = S_RUN;
      end
      S_RUN: begin
`ifndef MS_WDT_LOCK_EN
        if (!e) begin
          m_state = S_IDLE; m_irq = 0; m_last_key = -1;
        end else
`endif
        begin
          valid = kv && (kk == int'(KEY1)) && (m_last_key == int'(KEY0));
          if (valid) begin
            model_reload(le);
          end else begin
            if (kv) m_last_key = kk;
            m_n = m_n + 1;
            if (m_n % div == 0) begin
              m_ticks = m_ticks + 1;
              if (m_cnt() <= wr) m_irq = 1;
              if (m_cnt() == 0) begin
                m_state = S_FIRE; m_fired = 1; m_rstn = 0; m_pulse = 0;
              end
            end
          end
        end
      end
      default: begin
        m_last_key = -1;
        m_pulse = m_pulse + 1;
        if (m_pulse == PULSE_W) begin
          m_rstn = 1;
`ifdef MS_WDT_LOCK_EN
          m_state = S_RUN;
          model_reload(le);
`else
          m_state = S_IDLE;
`endif
        end
      end
    endcase
  endtask

  function automatic exp_t snapshot();
    exp_t x;
    x.phase = phase;
    x.count = CNT_W'(m_cnt());
    x.rstn  = m_rstn;
    x.irq   = m_irq;
    x.fired = m_fired;
    return x;
  endfunction

  task automatic chk(input string nm, input int ph, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s phase %0d t=%0t: got %0h, expected %0h", nm, ph, $time, act, req);
  endtask

  task automatic drive(input bit e, input int ld, input int wr, input int ps,
                       input bit kv, input int kk);
    @(negedge clk);
    rst        = 1'b0;
    en         = e;
    load       = CNT_W'(ld);
    warn       = CNT_W'(wr);
    prescale   = 2'(ps);
    kick_valid = kv;
    kick_key   = 8'(kk);
    model_step(e, ld, wr, ps, kv, kk);
    sb_q.push_back(snapshot());
  endtask

  // First entry is checked right after the asynchronous assert, second after the clock edge under reset.
  task automatic do_reset();
    @(negedge clk);
    model_reset();
    sb_q.push_back(snapshot());
    sb_q.push_back(snapshot());
    kick_valid = 1'b0;
    rst = 1'b1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk("count",     x.phase, 32'(count),     32'(x.count));
        chk("rst_req_n", x.phase, 32'(rst_req_n), 32'(x.rstn));
        chk("irq_warn",  x.phase, 32'(irq_warn),  32'(x.irq));
        chk("wdt_fired", x.phase, 32'(wdt_fired), 32'(x.fired));
      end
    end
  end

  initial begin : stimulus
    bit hit;
    int ld, wr, ps, kk;
    bit kv, e;

    model_reset();
    phase = 0;
    do_reset();

    // plain timeout: 10 ticks, 16-cycle pulse, back through IDLE
    phase = 1;
    for (int i = 0; i < 40; i++) drive(1, 10, 0, 0, 0, 0);

    // bad key sequence, then a valid kick landing on the terminal tick
    phase = 2;
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 20, 0, 0, 0, 0);
    drive(1, 20, 0, 0, 1, 'hA5);
    drive(1, 20, 0, 0, 1, 'h33);
    drive(1, 20, 0, 0, 1, 'h5A);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_state == S_RUN && m_cnt() == 2) hit = 1;
      else drive(1, 20, 0, 0, 0, 0);
    end
    chk("wait_cnt2", 2, 32'(hit), 32'd1);
    drive(1, 20, 0, 0, 1, 'hA5);
    drive(1, 20, 0, 0, 1, 'h5A);
    for (int i = 0; i < 5; i++) drive(1, 20, 0, 0, 0, 0);

    // early warning at count 5, cleared by a valid kick
    phase = 3;
    do_reset();
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_state == S_RUN && m_cnt() == 5) hit = 1;
      else drive(1, 20, 5, 0, 0, 0);
    end
    chk("wait_cnt5", 3, 32'(hit), 32'd1);
    drive(1, 20, 5, 0, 0, 0);
    drive(1, 20, 5, 0, 1, 'hA5);
    drive(1, 20, 5, 0, 1, 'h5A);
    drive(1, 20, 5, 0, 0, 0);

    // /16 prescale, kicked every 50 ticks, must never fire
    phase = 4;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      hit = 0;
      for (int i = 0; i < 1200 && !hit; i++) begin
        if (m_state == S_RUN && m_ticks >= 49) hit = 1;
        else drive(1, 100, 0, 1, 0, 0);
      end
      chk("wait_tick49", 4, 32'(hit), 32'd1);
      drive(1, 100, 0, 1, 1, 'hA5);
      drive(1, 100, 0, 1, 1, 'h5A);
    end
    for (int i = 0; i < 20; i++) drive(1, 100, 0, 1, 0, 0);

    // reset in the third FIRE cycle
    phase = 5;
    do_reset();
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (m_state == S_FIRE) hit = 1;
      else drive(1, 3, 0, 0, 0, 0);
    end
    chk("wait_fire", 5, 32'(hit), 32'd1);
    drive(0, 3, 0, 0, 0, 0);
    drive(0, 3, 0, 0, 1, 'hA5);
    do_reset();
    for (int i = 0; i < 4; i++) drive(0, 3, 0, 0, 0, 0);

    // en dropped mid-RUN
    phase = 6;
    for (int i = 0; i < 6; i++) drive(1, 30, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 30, 3, 0, 0, 0);
    for (int i = 0; i < 60; i++) drive(1, 30, 3, 0, 0, 0);

    // randomized segments
    phase = 7;
    do_reset();
    for (int s = 0; s < 15; s++) begin
      ld = $urandom_range(0, 30);
      wr = $urandom_range(0, 12);
      ps = ($urandom_range(0, 7) == 0) ? 1 : 0;
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 299) == 0) begin
          do_reset();
        end else begin
          e  = ($urandom_range(0, 15) != 0);
          kv = ($urandom_range(0, 3) == 0);
          case ($urandom_range(0, 3))
            0, 3:    kk = 'hA5;
            1:       kk = 'h5A;
            default: kk = $urandom_range(0, 255);
          endcase
          drive(e, ld, wr, ps, kv, kk);
        end
      end
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 8, 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ms_wdt.md
MS_WDT -- requirements
Module: ms_wdt

Interface
REQ-001 Parameter CNT_W, default 16, timeout counter width in bits.
REQ-002 Parameter PULSE_W, default 16, reset-request pulse length in clk cycles (>=1).
REQ-003 Parameter KEY0, default 8'hA5, first kick key.
REQ-004 Parameter KEY1, default 8'h5A, second kick key.
REQ-005 clk  input  1  single block clock; all state advances on posedge clk.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 en  input  1  watchdog enable, level.
REQ-008 load  input  CNT_W  timeout reload value, in prescaled ticks.
REQ-009 warn  input  CNT_W  early-warning threshold, in prescaled ticks.
REQ-010 prescale  input  2  tick divider: 00 /1, 01 /16, 10 /256, 11 /4096.
REQ-011 kick_valid  input  1  one-cycle kick strobe.
REQ-012 kick_key  input  8  key qualified by kick_valid.
REQ-013 rst_req_n  output  1  active-low reset request, for the system external-reset input.
REQ-014 irq_warn  output  1  early-warning interrupt, level.
REQ-015 wdt_fired  output  1  sticky flag: a timeout has occurred.
REQ-016 count  output  CNT_W  current counter value.

Function
REQ-017 FSM states SHALL be IDLE, RUN and FIRE.
REQ-018 IDLE: count SHALL be held at load (0 treated as 1), prescaler cleared, unlock cleared; en=1 SHALL move to RUN on the next edge.
REQ-019 RUN: prescaler SHALL be a 12-bit free counter; a tick SHALL occur when its low 0/4/8/12 bits, selected by prescale, are all ones.
REQ-020 RUN: each tick SHALL decrement count by 1; a tick with count==1 SHALL set count=0 and enter FIRE on the same edge.
REQ-021 Kick: kick_valid with KEY0 SHALL set unlock; the next kick_valid carrying KEY1 while unlocked SHALL be a valid kick; any other kick_valid SHALL clear unlock.
REQ-022 A valid kick in RUN SHALL reload count from load, clear the prescaler, clear unlock and clear irq_warn on the next edge.
REQ-023 A valid kick in the same cycle as the terminal tick SHALL win: reload, no FIRE.
REQ-024 Kicks in IDLE or FIRE SHALL be ignored and SHALL clear unlock.
REQ-025 irq_warn SHALL set on the edge where count becomes <= warn in RUN; it SHALL stay set until a valid kick, IDLE or rst.
REQ-026 FIRE: rst_req_n SHALL be 0 for exactly PULSE_W cycles, then the FSM SHALL return to IDLE, with rst_req_n=1 at that edge.
REQ-027 FIRE entry SHALL set wdt_fired; only rst SHALL clear it.
REQ-028 en=0 during FIRE SHALL NOT shorten the pulse.
REQ-029 load, warn and prescale changes SHALL take effect only at the next reload or tick comparison; no retroactive effect.

Reset
REQ-030 rst SHALL force asynchronously: state IDLE, count=0, prescaler=0, unlock=0, rst_req_n=1, irq_warn=0, wdt_fired=0.
REQ-031 rst asserted mid-FIRE SHALL terminate the pulse immediately (rst_req_n=1).
REQ-032 After rst deassertion, count SHALL load from load on the first edge in IDLE.

Configuration
REQ-033 Macro MS_WDT_LOCK_EN: when defined, once RUN is entered en SHALL be ignored until rst, and FIRE SHALL return to RUN (reloaded) instead of IDLE.
REQ-034 Without MS_WDT_LOCK_EN: en=0 in RUN SHALL move to IDLE on the next edge and clear irq_warn.

Verification
REQ-035 load=10, prescale=00, en=1, no kicks -> count counts 10..1, FIRE after 10 ticks; rst_req_n low 16 cycles; wdt_fired=1.
REQ-036 load=100, prescale=01, kick A5 then 5A every 50 ticks -> rst_req_n never low; count reloads to 100 after each second kick.
REQ-037 Kick sequence A5,33,5A -> no reload; A5,5A landing on the count==1 tick -> reload, no FIRE.
REQ-038 load=20, warn=5 -> irq_warn rises when count becomes 5; a valid kick clears it the next cycle.
REQ-039 rst pulsed during FIRE cycle 3 -> rst_req_n=1 immediately, wdt_fired=0, state IDLE.
REQ-040 en dropped in RUN: without macro -> IDLE next cycle; with MS_WDT_LOCK_EN -> keeps counting, FIRE, back to RUN.
